stopwatch_mmss: RTL
===================

# stopwatch_mmss

Minutes:seconds stopwatch that consumes the 1 Hz output of `clock_divider` and drives four seven-segment displays. It runs in the 50 MHz domain and treats `clk_1Hz` as a data input: it synchronizes the signal, detects its rising edge, and uses the resulting one-cycle tick as a count enable. Start/stop and clear are debounced level inputs from the board buttons.

## Interface
- `MAX_MIN`, default 59: highest minutes value, legal range 1..59. The display wraps after `MAX_MIN`:59.
- `clk_50MHz` input 1: sole clock. All state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `clk_1Hz` input 1: divider output. Asynchronous to this block's logic and sampled as data.
- `start_stop` input 1: debounced level. Each rising edge is one press.
- `clear` input 1: debounced level. Each rising edge is one press.
- `sec_ones` output 4: BCD seconds units, 0..9.
- `sec_tens` output 4: BCD seconds tens, 0..5.
- `min_ones` output 4: BCD minutes units, 0..9.
- `min_tens` output 4: BCD minutes tens, 0..5.
- `hex0`..`hex3` output 7 each: active-low segments, bit order {g,f,e,d,c,b,a}. `hex0` shows `sec_ones` and `hex3` shows `min_tens`.
- `running` output 1: high while in RUN.
- `rollover` output 1: one-cycle pulse when the count wraps to 00:00.

## Operation
- **Input conditioning.** `clk_1Hz`, `start_stop` and `clear` each pass through a 2-FF synchronizer and then an edge-detect flop.
  - `tick`, `ss_evt` and `clr_evt` are each `sync2 & ~sync3`.
  - Each event is exactly one cycle long per input rising edge.
- **FSM states:** IDLE (count 00:00, stopped), RUN, PAUSE.
  - IDLE: `ss_evt` moves to RUN. `clr_evt` has no effect.
  - RUN: `ss_evt` moves to PAUSE. `clr_evt` is ignored.
  - PAUSE: `ss_evt` moves to RUN. `clr_evt` moves to IDLE and zeroes all digits.
- **Simultaneous events:**
  - In PAUSE, `clr_evt` wins over `ss_evt`: next state is IDLE.
  - In RUN, `ss_evt` is taken and `clr_evt` is dropped.
  - A `tick` in the same cycle that RUN goes to PAUSE still counts.
  - A `tick` in the same cycle that IDLE or PAUSE goes to RUN is not counted.
- **Counting.** The count advances by one second only when state is RUN and `tick` is high.
  - Standard BCD cascade: `sec_ones` 9 goes to 0 and carries, `sec_tens` 5 goes to 0 and carries, `min_ones` 9 goes to 0 and carries.
  - At `MAX_MIN`:59, the next tick gives 00:00 and `rollover` is high for that cycle.
  - State stays RUN after a wrap.
- **Display.** Segment decode is combinational from the registered digits.
  - Codes: 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000.
  - Out-of-range nibbles (unreachable) show blank, 1111111.
- **Reset.** Reset dominates every event. All synchronizer flops, the FSM and the digits clear.

## Timing
- **Reset values:**
  - All digits 0.
  - `hex0`..`hex3` = 1000000.
  - `running` = 0, `rollover` = 0.
  - State IDLE.
  - Synchronizers 0, so a `clk_1Hz` that is already high when reset releases produces a tick.
- **Latency.** Input rises before edge k:
  - `sync1` is set at edge k and `sync2` at edge k+1.
  - The event is high for the cycle between edges k+1 and k+2.
  - The digit or state update appears after edge k+2, which is 3 edges from the input change.
- `running` is registered (derived from the state register) and changes on the same edge as the state.
- `rollover` is registered and high for exactly one cycle, aligned with the digits reading 00:00.
- A held-high `start_stop` or `clear` produces a single event. There is no auto-repeat.
- The minimum input high or low width for detection is 2 cycles.

## Test plan
- **Reset and idle.**
  - Assert `rst` for 2 cycles with `clk_1Hz` toggling: all digits 0, `hex0`..`hex3` = 1000000, `running` = 0.
  - 5 ticks in IDLE: the count stays 00:00.
- **Start and count.** Press `start_stop`, then give 75 rising edges on `clk_1Hz`, each high ≥4 cycles:
  - The count reads 01:15 and `hex0` = 0010010.
  - Each digit changes exactly 3 edges after its `clk_1Hz` rise.
- **Pause and clear.**
  - Press `start_stop`, then give 10 ticks: the count holds at 01:15.
  - Press `clear`: 00:00, IDLE.
  - Press `clear` while in RUN: ignored, counting continues.
- **Wrap.**
  - Force the count by running to 59:58 with `MAX_MIN`=59, then give 2 ticks: 59:59, then 00:00.
  - `rollover` is high for exactly 1 cycle and `running` stays 1.
  - Repeat with `MAX_MIN`=2: 02:59 wraps to 00:00.
- **Simultaneous events.**
  - In PAUSE, raise `start_stop` and `clear` on the same cycle: result is IDLE, 00:00.
  - In RUN, align a `tick` with `ss_evt`: the count increments and the state becomes PAUSE.
- **Reset mid-run.** At 12:34, assert `rst` for 1 cycle: next cycle shows 00:00, IDLE, `rollover` = 0.

Source files
------------

// File: rtl/stopwatch_mmss.sv
// stopwatch_mmss: minutes:seconds stopwatch for four seven-segment displays.
//
// Runs entirely in the 50 MHz domain. The 1 Hz divider output and the two
// debounced buttons are treated as asynchronous data inputs. Each one is
// double-flopped, then rising-edge detected into a single-cycle event.
//
// Ports:
//   clk_50MHz   sole clock, rising edge
//   rst         synchronous active-high reset; dominates every event
//   clk_1Hz     divider output; each rising edge is one count tick
//   start_stop  debounced button level; each rising edge toggles run/pause
//   clear       debounced button level; each rising edge clears while paused
//   sec_ones, sec_tens, min_ones, min_tens   registered BCD digits
//   hex0..hex3  active-low segments {g,f,e,d,c,b,a}; hex0 = sec_ones,
//               hex3 = min_tens
//   running     registered, high while the FSM is in RUN
//   rollover    registered one-cycle pulse aligned with the wrap to 00:00
module stopwatch_mmss #(
  parameter int MAX_MIN = 59
) (
  input  logic       clk_50MHz,
  input  logic       rst,
  input  logic       clk_1Hz,
  input  logic       start_stop,
  input  logic       clear,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic       running,
  output logic       rollover
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam logic [3:0] MAX_MIN_TENS = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_MIN_ONES = 4'(MAX_MIN % 10);

  // Active-low seven-segment code; unreachable nibbles render blank.
  function automatic logic [6:0] seg7(input logic [3:0] digit);
    logic [6:0] code;
    case (digit)
      4'd0:    code = 7'b1000000;
      4'd1:    code = 7'b1111001;
      4'd2:    code = 7'b0100100;
      4'd3:    code = 7'b0110000;
      4'd4:    code = 7'b0011001;
      4'd5:    code = 7'b0010010;
      4'd6:    code = 7'b0000010;
      4'd7:    code = 7'b1111000;
      4'd8:    code = 7'b0000000;
      4'd9:    code = 7'b0010000;
      default: code = 7'b1111111;
    endcase
    return code;
  endfunction

  // Bit 0 = clk_1Hz, bit 1 = start_stop, bit 2 = clear.
  logic [2:0] sync1_r;
  logic [2:0] sync2_r;
  logic [2:0] sync3_r;
  logic       tick_s;
  logic       ss_evt_s;
  logic       clr_evt_s;

  state_t     state_r;
  state_t     next_state_s;
  logic       zero_s;
  logic       count_en_s;
  logic       at_max_s;

  logic [3:0] sec_ones_r;
  logic [3:0] sec_tens_r;
  logic [3:0] min_ones_r;
  logic [3:0] min_tens_r;
  logic       running_r;
  logic       rollover_r;

  // Two-flop synchronizers plus one edge-detect flop per input.
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      sync1_r <= 3'b000;
      sync2_r <= 3'b000;
      sync3_r <= 3'b000;
    end else begin
      sync1_r <= {clear, start_stop, clk_1Hz};
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
    end
  end

  assign tick_s    = sync2_r[0] & ~sync3_r[0];
  assign ss_evt_s  = sync2_r[1] & ~sync3_r[1];
  assign clr_evt_s = sync2_r[2] & ~sync3_r[2];

  // Next-state logic. Clear only acts from PAUSE and beats start_stop there.
  always_comb begin
    next_state_s = state_r;
    zero_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (ss_evt_s) begin
          next_state_s = ST_RUN;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (ss_evt_s) begin
          next_state_s = ST_PAUSE;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (clr_evt_s) begin
          next_state_s = ST_IDLE;
          zero_s       = 1'b1;
        end else if (ss_evt_s) begin
          next_state_s = ST_RUN;
        end else begin
          next_state_s = ST_PAUSE;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
        zero_s       = 1'b1;
      end
    endcase
  end

  // Counting is qualified by the current state, so a tick coinciding with
  // RUN->PAUSE counts and one coinciding with entry into RUN does not.
  assign count_en_s = (state_r == ST_RUN) && tick_s;
  assign at_max_s   = (min_tens_r == MAX_MIN_TENS) && (min_ones_r == MAX_MIN_ONES) &&
                      (sec_tens_r == 4'd5) && (sec_ones_r == 4'd9);

  // State register; running is derived from the next state so it moves
  // on the same edge as the state itself.
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      running_r <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      running_r <= (next_state_s == ST_RUN);
    end
  end

  // BCD cascade with wrap to 00:00 after MAX_MIN:59.
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      sec_ones_r <= 4'd0;
      sec_tens_r <= 4'd0;
      min_ones_r <= 4'd0;
      min_tens_r <= 4'd0;
      rollover_r <= 1'b0;
    end else begin
      rollover_r <= 1'b0;
      if (zero_s) begin
        sec_ones_r <= 4'd0;
        sec_tens_r <= 4'd0;
        min_ones_r <= 4'd0;
        min_tens_r <= 4'd0;
      end else if (count_en_s) begin
        if (at_max_s) begin
          sec_ones_r <= 4'd0;
          sec_tens_r <= 4'd0;
          min_ones_r <= 4'd0;
          min_tens_r <= 4'd0;
          rollover_r <= 1'b1;
        end else if (sec_ones_r != 4'd9) begin
          sec_ones_r <= sec_ones_r + 4'd1;
        end else begin
          sec_ones_r <= 4'd0;
          if (sec_tens_r != 4'd5) begin
            sec_tens_r <= sec_tens_r + 4'd1;
          end else begin
            sec_tens_r <= 4'd0;
            if (min_ones_r != 4'd9) begin
              min_ones_r <= min_ones_r + 4'd1;
            end else begin
              min_ones_r <= 4'd0;
              min_tens_r <= min_tens_r + 4'd1;
            end
          end
        end
      end else begin
        sec_ones_r <= sec_ones_r;
        sec_tens_r <= sec_tens_r;
        min_ones_r <= min_ones_r;
        min_tens_r <= min_tens_r;
      end
    end
  end

  assign sec_ones = sec_ones_r;
  assign sec_tens = sec_tens_r;
  assign min_ones = min_ones_r;
  assign min_tens = min_tens_r;
  assign running  = running_r;
  assign rollover = rollover_r;

  assign hex0 = seg7(sec_ones_r);
  assign hex1 = seg7(sec_tens_r);
  assign hex2 = seg7(min_ones_r);
  assign hex3 = seg7(min_tens_r);

endmodule
